pc_fetch_unit: RTL

Program counter, 8-level hardware return stack and instruction register for the PIC16F core. It is the responder to the instruction decoder's fetch/branch controls. It acts on `instr_rd_en`, `instr_flush`, `pc_incr_en`, `pc_j_en`, `pc_j_and_push_en` and `pc_j_by_pop_en`. It drives program-memory addresses and presents `instr_current` back to the decoder.

---
 rtl/pc_fetch_unit_pkg.sv | 29 ++
 rtl/pc_fetch_unit_if.sv | 36 +++
 rtl/pc_fetch_unit_return_stack.sv | 67 ++++++
 rtl/pc_fetch_unit.sv | 74 +++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PIC16F fetch path: default widths, the NOP
// encoding and the PC-source selection used by pc_fetch_unit.
package pc_fetch_unit_pkg;

  localparam int PC_WIDTH_DEF    = 13;
  localparam int INSTR_WIDTH_DEF = 14;
  localparam int STACK_DEPTH_DEF = 8;

  localparam logic [13:0] NOP_WORD = 14'h0000;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INCR,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_sel_e;

  // Return beats call beats goto beats increment; anything lower is ignored.
  function automatic pc_sel_e pc_select(input logic pop, input logic call,
                                        input logic jump, input logic incr);
    if (pop)       return PC_RET;
    else if (call) return PC_CALL;
    else if (jump) return PC_JUMP;
    else if (incr) return PC_INCR;
    else           return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Decoder/program-memory side of the fetch unit: branch/fetch controls in,
// fetch address, instruction register and stack status out.
interface pc_fetch_unit_if
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) ();

  logic                   pc_incr_en;
  logic                   pc_j_en;
  logic                   pc_j_and_push_en;
  logic                   pc_j_by_pop_en;
  logic                   instr_rd_en;
  logic                   instr_flush;
  logic [PC_WIDTH-12:0]   pclath_hi;
  logic [PC_WIDTH-1:0]    prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic [INSTR_WIDTH-1:0] instr_current;
  logic [PC_WIDTH-1:0]    pc;
  logic                   stack_ovf;
  logic                   stack_unf;

  modport master (
    output pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
    output instr_rd_en, instr_flush, pclath_hi, prog_data,
    input  prog_addr, instr_current, pc, stack_ovf, stack_unf
  );

  modport slave (
    input  pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
    input  instr_rd_en, instr_flush, pclath_hi, prog_data,
    output prog_addr, instr_current, pc, stack_ovf, stack_unf
  );

endinterface

// File: rtl/pc_fetch_unit_return_stack.sv
// Circular hardware return stack: oldest entry is overwritten on overflow,
// a stale entry is returned on underflow, both events latch sticky flags.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ovf,
  output logic             unf
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp_reg, sp_next, sp_dec;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;

  // Pop must deliver the return address on the same edge, so the read is
  // combinational from the entry just below the pointer.
  assign sp_dec = sp_reg - SP_W'(1);
  assign dout   = mem[sp_dec];
  assign ovf    = ovf_reg;
  assign unf    = unf_reg;

  always_comb begin
    sp_next  = sp_reg;
    occ_next = occ_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    if (pop) begin
      sp_next = sp_dec;
      if (occ_reg == '0) unf_next = 1'b1;
      else               occ_next = occ_reg - OCC_W'(1);
    end else if (push) begin
      sp_next = sp_reg + SP_W'(1);
      if (occ_reg == OCC_W'(DEPTH)) ovf_next = 1'b1;
      else                          occ_next = occ_reg + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_reg  <= '0;
      occ_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      sp_reg  <= sp_next;
      occ_reg <= occ_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop) mem[sp_reg] <= din;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and return stack for the PIC16F
// core; PC always points at the next word to prefetch.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_unit_if.slave   bus
);

  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [INSTR_WIDTH-1:0] ir_reg, ir_next;
  logic [PC_WIDTH-1:0]    jump_target;
  logic [PC_WIDTH-1:0]    stack_dout;
  logic                   stack_push;
  logic                   stack_pop;
  pc_sel_e                pc_sel;

  assign pc_sel      = pc_select(bus.pc_j_by_pop_en, bus.pc_j_and_push_en,
                                 bus.pc_j_en, bus.pc_incr_en);
  assign jump_target = {bus.pclath_hi, ir_reg[10:0]};
  assign stack_pop   = (pc_sel == PC_RET);
  assign stack_push  = (pc_sel == PC_CALL);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (stack_push),
    .pop  (stack_pop),
    .din  (pc_reg),
    .dout (stack_dout),
    .ovf  (bus.stack_ovf),
    .unf  (bus.stack_unf)
  );

  always_comb begin
    pc_next = pc_reg;
    case (pc_sel)
      PC_RET:           pc_next = stack_dout;
      PC_CALL, PC_JUMP: pc_next = jump_target;
      PC_INCR:          pc_next = pc_reg + PC_WIDTH'(1);
      default:          pc_next = pc_reg;
    endcase
  end

  // Flush wins so a skipped or branched-over word never reaches the decoder.
  always_comb begin
    ir_next = ir_reg;
    if (bus.instr_flush)      ir_next = INSTR_WIDTH'(NOP_WORD);
    else if (bus.instr_rd_en) ir_next = bus.prog_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= '0;
      ir_reg <= INSTR_WIDTH'(NOP_WORD);
    end else begin
      pc_reg <= pc_next;
      ir_reg <= ir_next;
    end
  end

  assign bus.prog_addr     = pc_reg;
  assign bus.pc            = pc_reg;
  assign bus.instr_current = ir_reg;

endmodule
